// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states and opcode classification helpers.
package alu_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_SLTU = 4'b1011;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_MULU = 4'b1101;
   localparam logic [3:0] OP_DIVU = 4'b1110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   function automatic logic is_long_op(input logic [3:0] op);
      return (op == OP_MULU) || (op == OP_DIVU);
   endfunction

   function automatic logic is_reserved(input logic [3:0] op);
      logic res;
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB, OP_SLT, OP_SLL, OP_SRL,
         OP_SRA, OP_SLTU, OP_NOR, OP_MULU, OP_DIVU: res = 1'b0;
         default:                                  res = 1'b1;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/alu_simple.sv
// Combinational single-cycle ALU operations: logic, add/sub with signed overflow, compares and shifts.
module alu_simple
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             overflow
);

   localparam int SHAMT_W = $clog2(WIDTH);

   logic [WIDTH-1:0]   sum;
   logic [WIDTH-1:0]   diff;
   logic               addOvf;
   logic               subOvf;
   logic [SHAMT_W-1:0] shamt;

   // SLT takes the sign of A-B and flips it when the subtraction overflowed.
   always_comb begin
      sum      = a + b;
      diff     = a - b;
      addOvf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      subOvf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      shamt    = b[SHAMT_W-1:0];
      result   = '0;
      overflow = 1'b0;
      case (op)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOR:  result = ~(a | b);
         OP_ADD:  begin
            result   = sum;
            overflow = addOvf;
         end
         OP_SUB:  begin
            result   = diff;
            overflow = subOvf;
         end
         OP_SLT:  result = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ subOvf};
         OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SLL:  result = a << shamt;
         OP_SRL:  result = a >> shamt;
         OP_SRA:  result = $unsigned($signed(a) >>> shamt);
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU for the EX stage: single-cycle ops plus iterative MULU/DIVU behind valid/ready handshakes.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic [3:0]       Signal,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dataOut,
   output logic [WIDTH-1:0] dataHi,
   output logic             zero,
   output logic             overflow,
   output logic             div_zero,
   output logic             illegal,
   output logic             busy
);

   localparam int SHAMT_W = $clog2(WIDTH);

   state_t             state;
   state_t             nextState;
   logic               started;
   logic [SHAMT_W-1:0] count;
   logic [WIDTH-1:0]   hiReg;
   logic [WIDTH-1:0]   loReg;
   logic [WIDTH-1:0]   opReg;

   logic [WIDTH-1:0]   simpleResult;
   logic               simpleOvf;
   logic               acceptOp;
   logic               longStart;
   logic [WIDTH-1:0]   imOut;
   logic [WIDTH-1:0]   imHi;
   logic               imOvf;
   logic               imDz;
   logic               imIll;
   logic [WIDTH:0]     mulSum;
   logic [WIDTH-1:0]   mulHiNext;
   logic [WIDTH-1:0]   mulLoNext;
   logic [WIDTH:0]     divShift;
   logic [WIDTH:0]     divDiff;
   logic               divGe;
   logic [WIDTH-1:0]   divHiNext;
   logic [WIDTH-1:0]   divLoNext;

   alu_simple #(.WIDTH(WIDTH)) u_simple (
      .a        (dataA),
      .b        (dataB),
      .op       (Signal),
      .result   (simpleResult),
      .overflow (simpleOvf)
   );

   // started keeps in_ready low until the first edge after reset is released.
   always_comb begin
      in_ready  = started && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
      out_valid = (state == S_DONE);
      busy      = (state == S_MUL) || (state == S_DIV);
      acceptOp  = in_ready && in_valid;
      longStart = is_long_op(Signal) && !((Signal == OP_DIVU) && (dataB == '0));
   end

   // Results that are ready the cycle after acceptance, including div-by-zero and reserved opcodes.
   always_comb begin
      imOut = simpleResult;
      imHi  = '0;
      imOvf = simpleOvf;
      imDz  = 1'b0;
      imIll = 1'b0;
      if (is_reserved(Signal)) begin
         imOut = '0;
         imOvf = 1'b0;
         imIll = 1'b1;
      end else if (Signal == OP_DIVU) begin
         imOut = '1;
         imHi  = dataA;
         imDz  = 1'b1;
      end
   end

   // One shift-add multiply step and one restoring-divide step; hi/lo hold product or remainder/quotient.
   always_comb begin
      mulSum    = {1'b0, hiReg} + (loReg[0] ? {1'b0, opReg} : '0);
      mulHiNext = mulSum[WIDTH:1];
      mulLoNext = {mulSum[0], loReg[WIDTH-1:1]};
      divShift  = {hiReg, loReg[WIDTH-1]};
      divDiff   = divShift - {1'b0, opReg};
      divGe     = !divDiff[WIDTH];
      divHiNext = divGe ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
      divLoNext = {loReg[WIDTH-2:0], divGe};
   end

   always_comb begin
      nextState = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (acceptOp) begin
               if (longStart) nextState = (Signal == OP_MULU) ? S_MUL : S_DIV;
               else           nextState = S_DONE;
            end else if ((state == S_DONE) && out_ready) begin
               nextState = S_IDLE;
            end
         end
         S_MUL, S_DIV: if (count == '0) nextState = S_DONE;
         default: nextState = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= nextState;
   end

   // Iteration registers and result/flag registers; result registers load on the final iteration or on accept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         started  <= 1'b0;
         count    <= '0;
         hiReg    <= '0;
         loReg    <= '0;
         opReg    <= '0;
         dataOut  <= '0;
         dataHi   <= '0;
         zero     <= 1'b0;
         overflow <= 1'b0;
         div_zero <= 1'b0;
         illegal  <= 1'b0;
      end else begin
         started <= 1'b1;
         case (state)
            S_MUL: begin
               hiReg <= mulHiNext;
               loReg <= mulLoNext;
               count <= count - 1'b1;
               if (count == '0) begin
                  dataOut  <= mulLoNext;
                  dataHi   <= mulHiNext;
                  zero     <= (mulLoNext == '0);
                  overflow <= 1'b0;
                  div_zero <= 1'b0;
                  illegal  <= 1'b0;
               end
            end
            S_DIV: begin
               hiReg <= divHiNext;
               loReg <= divLoNext;
               count <= count - 1'b1;
               if (count == '0) begin
                  dataOut  <= divLoNext;
                  dataHi   <= divHiNext;
                  zero     <= (divLoNext == '0);
                  overflow <= 1'b0;
                  div_zero <= 1'b0;
                  illegal  <= 1'b0;
               end
            end
            default: begin
               if (acceptOp) begin
                  if (longStart) begin
                     count <= SHAMT_W'(WIDTH - 1);
                     hiReg <= '0;
                     if (Signal == OP_MULU) begin
                        loReg <= dataB;
                        opReg <= dataA;
                     end else begin
                        loReg <= dataA;
                        opReg <= dataB;
                     end
                  end else begin
                     dataOut  <= imOut;
                     dataHi   <= imHi;
                     zero     <= (imOut == '0);
                     overflow <= imOvf;
                     div_zero <= imDz;
                     illegal  <= imIll;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed scenarios plus randomized ops against an arithmetic reference model.
module tb_alu_mc;

   localparam int W = 32;
   localparam longint MAXS = 64'sd2147483647;
   localparam longint MINS = -64'sd2147483648;

   typedef struct packed {
      logic [W-1:0] out;
      logic [W-1:0] hi;
      logic         z;
      logic         ov;
      logic         dz;
      logic         il;
      int           lat;
   } expect_t;

   logic         clk;
   logic         reset;
   logic         inValid;
   logic         inReady;
   logic [W-1:0] dataA;
   logic [W-1:0] dataB;
   logic [3:0]   opcode;
   logic         outValid;
   logic         outReady;
   logic [W-1:0] dataOut;
   logic [W-1:0] dataHi;
   logic         zero;
   logic         overflow;
   logic         divZero;
   logic         illegal;
   logic         busy;

   int checks = 0;
   int errors = 0;

   alu_mc #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .dataA     (dataA),
      .dataB     (dataB),
      .Signal    (opcode),
      .out_valid (outValid),
      .out_ready (outReady),
      .dataOut   (dataOut),
      .dataHi    (dataHi),
      .zero      (zero),
      .overflow  (overflow),
      .div_zero  (divZero),
      .illegal   (illegal),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain wide arithmetic, independent of how the hardware iterates.
   function automatic expect_t refModel(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      expect_t e;
      longint  sa;
      longint  sb;
      longint  s;
      logic [2*W-1:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e = '0;
      e.lat = 1;
      case (op)
         4'b0000: e.out = a & b;
         4'b0001: e.out = a | b;
         4'b0011: e.out = a ^ b;
         4'b1100: e.out = ~(a | b);
         4'b0010: begin
            s = sa + sb;
            e.out = a + b;
            e.ov = (s > MAXS) || (s < MINS);
         end
         4'b0110: begin
            s = sa - sb;
            e.out = a - b;
            e.ov = (s > MAXS) || (s < MINS);
         end
         4'b0111: e.out = (sa < sb) ? 32'd1 : 32'd0;
         4'b1011: e.out = (a < b) ? 32'd1 : 32'd0;
         4'b1000: e.out = a << b[4:0];
         4'b1001: e.out = a >> b[4:0];
         4'b1010: e.out = $unsigned($signed(a) >>> b[4:0]);
         4'b1101: begin
            p = {32'd0, a} * {32'd0, b};
            e.out = p[W-1:0];
            e.hi = p[2*W-1:W];
            e.lat = W + 1;
         end
         4'b1110: begin
            if (b == 0) begin
               e.out = '1;
               e.hi = a;
               e.dz = 1'b1;
            end else begin
               e.out = a / b;
               e.hi = a % b;
               e.lat = W + 1;
            end
         end
         default: e.il = 1'b1;
      endcase
      e.z = (e.out == 0);
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkResult(input string tag, input expect_t e);
      checkOutput({tag, ".valid"}, 64'(outValid), 64'd1);
      checkOutput({tag, ".dataOut"}, 64'(dataOut), 64'(e.out));
      checkOutput({tag, ".dataHi"}, 64'(dataHi), 64'(e.hi));
      checkOutput({tag, ".zero"}, 64'(zero), 64'(e.z));
      checkOutput({tag, ".overflow"}, 64'(overflow), 64'(e.ov));
      checkOutput({tag, ".div_zero"}, 64'(divZero), 64'(e.dz));
      checkOutput({tag, ".illegal"}, 64'(illegal), 64'(e.il));
   endtask

   // Issue one op with out_ready high, wait for the result with a bounded loop, then check it and its timing.
   task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      expect_t e;
      int      lat;
      int      wait_n;
      int      busyCycles;
      int      badStall;
      e = refModel(op, a, b);
      opcode   = op;
      dataA    = a;
      dataB    = b;
      outReady = 1'b1;
      inValid  = 1'b1;
      wait_n = 0;
      while (!inReady && wait_n < 50) begin
         @(negedge clk);
         wait_n++;
      end
      checkOutput({tag, ".in_ready"}, 64'(inReady), 64'd1);
      @(posedge clk);
      @(negedge clk);
      inValid = 1'b0;
      dataA   = $urandom;
      dataB   = $urandom;
      opcode  = 4'($urandom_range(0, 15));
      lat = 1;
      busyCycles = 0;
      badStall = 0;
      while (!outValid && lat < 100) begin
         busyCycles += int'(busy);
         if (!busy || inReady) badStall++;
         @(negedge clk);
         lat++;
      end
      checkOutput({tag, ".latency"}, 64'(lat), 64'(e.lat));
      checkOutput({tag, ".busyCycles"}, 64'(busyCycles), 64'(e.lat - 1));
      checkOutput({tag, ".stall"}, 64'(badStall), 64'd0);
      checkResult(tag, e);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      expect_t e;
      logic [3:0] op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] held;

      reset    = 1'b0;
      inValid  = 1'b0;
      outReady = 1'b0;
      dataA    = '0;
      dataB    = '0;
      opcode   = '0;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst.in_ready", 64'(inReady), 64'd0);
      checkOutput("rst.out_valid", 64'(outValid), 64'd0);
      checkOutput("rst.busy", 64'(busy), 64'd0);
      checkOutput("rst.dataOut", 64'(dataOut), 64'd0);
      reset = 1'b1;
      #1;
      checkOutput("rel.in_ready_early", 64'(inReady), 64'd0);
      @(negedge clk);
      checkOutput("rel.in_ready", 64'(inReady), 64'd1);

      // ADD overflow right after reset
      applyStimulus("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'd1);
      checkOutput("add_ovf.const", 64'(dataOut), 64'h8000_0000);

      // Back-to-back SUB, SLT, SRA with in_valid every cycle
      @(negedge clk);
      outReady = 1'b1;
      inValid = 1'b1; opcode = 4'b0110; dataA = 32'd5; dataB = 32'd5;
      @(posedge clk); @(negedge clk);
      checkResult("b2b_sub", refModel(4'b0110, 32'd5, 32'd5));
      checkOutput("b2b_sub.zero1", 64'(zero), 64'd1);
      checkOutput("b2b.in_ready", 64'(inReady), 64'd1);
      opcode = 4'b0111; dataA = 32'hFFFF_FFFF; dataB = 32'd1;
      @(posedge clk); @(negedge clk);
      checkResult("b2b_slt", refModel(4'b0111, 32'hFFFF_FFFF, 32'd1));
      checkOutput("b2b_slt.const", 64'(dataOut), 64'd1);
      opcode = 4'b1010; dataA = 32'h8000_0000; dataB = 32'd4;
      @(posedge clk); @(negedge clk);
      inValid = 1'b0;
      checkResult("b2b_sra", refModel(4'b1010, 32'h8000_0000, 32'd4));
      checkOutput("b2b_sra.const", 64'(dataOut), 64'hF800_0000);
      @(negedge clk);
      checkOutput("b2b.idle_valid", 64'(outValid), 64'd0);

      // Long ops and divide by zero
      applyStimulus("mulu", 4'b1101, 32'hFFFF_FFFF, 32'd2);
      checkOutput("mulu.const", {dataHi, dataOut}, 64'h1_FFFF_FFFE);
      applyStimulus("divu", 4'b1110, 32'd100, 32'd7);
      checkOutput("divu.const", {dataHi, dataOut}, {32'd2, 32'd14});
      applyStimulus("divz", 4'b1110, 32'd9, 32'd0);
      checkOutput("divz.const", {dataHi, dataOut}, {32'd9, 32'hFFFF_FFFF});
      applyStimulus("illegal", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);

      // Backpressure: hold an XOR result for 5 cycles
      @(negedge clk);
      outReady = 1'b0;
      inValid = 1'b1; opcode = 4'b0011; dataA = 32'hA5A5_0F0F; dataB = 32'h0FF0_FFFF;
      @(posedge clk); @(negedge clk);
      e = refModel(4'b0011, 32'hA5A5_0F0F, 32'h0FF0_FFFF);
      held = e.out;
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("bp%0d.valid", i), 64'(outValid), 64'd1);
         checkOutput($sformatf("bp%0d.dataOut", i), 64'(dataOut), 64'(held));
         checkOutput($sformatf("bp%0d.in_ready", i), 64'(inReady), 64'd0);
         @(negedge clk);
      end
      inValid = 1'b0;
      outReady = 1'b1;
      @(negedge clk);
      checkOutput("bp.released_valid", 64'(outValid), 64'd0);
      checkOutput("bp.released_ready", 64'(inReady), 64'd1);

      // Reset in the middle of a DIVU
      inValid = 1'b1; opcode = 4'b1110; dataA = 32'hDEAD_BEEF; dataB = 32'd3;
      @(posedge clk); @(negedge clk);
      inValid = 1'b0;
      repeat (9) @(negedge clk);
      checkOutput("mid.busy", 64'(busy), 64'd1);
      reset = 1'b0;
      #1;
      checkOutput("mid.outs", {dataOut, dataHi}, 64'd0);
      checkOutput("mid.flags", {59'd0, busy, outValid, inReady, divZero, zero}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("mid.in_ready", 64'(inReady), 64'd1);
      checkOutput("mid.out_valid", 64'(outValid), 64'd0);

      // Randomized ops with boundary-weighted operands
      for (int n = 0; n < 60; n++) begin
         op = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 5))
            0: a = '0;
            1: a = '1;
            2: a = 32'h8000_0000;
            3: a = 32'h7FFF_FFFF;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 6))
            0: b = '0;
            1: b = '1;
            2: b = 32'h8000_0000;
            3: b = 32'($urandom_range(1, 40));
            default: b = $urandom;
         endcase
         applyStimulus($sformatf("rnd%0d_op%0h", n, op), op, a, b);
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
